// File: rtl/dsp48a1_pkg.sv
// Purpose: shared widths, OPMODE bit positions and X/Z mux encodings for the DSP48A1 slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dsp48a1_pkg;

  localparam int P_W = 48;
  localparam int M_W = 36;

  localparam int OPM_SUB = 7;
  localparam int OPM_CIN = 5;

  typedef enum logic [1:0] {
    X_ZERO = 2'd0,
    X_M    = 2'd1,
    X_P    = 2'd2,
    X_DAB  = 2'd3
  } x_sel_e;

  typedef enum logic [1:0] {
    Z_ZERO = 2'd0,
    Z_PCIN = 2'd1,
    Z_P    = 2'd2,
    Z_C    = 2'd3
  } z_sel_e;

  function automatic x_sel_e opm_x(input logic [7:0] opm);
    return x_sel_e'(opm[1:0]);
  endfunction

  function automatic z_sel_e opm_z(input logic [7:0] opm);
    return z_sel_e'(opm[3:2]);
  endfunction

endpackage

// File: rtl/dsp_post_adder_core.sv
// Purpose: X/Z operand muxes and the 49-bit unsigned add/subtract of the post-adder.
// Latency: purely combinational.
// Backpressure: none; result follows inputs.
module dsp_post_adder_core
  import dsp48a1_pkg::*;
(
  input  x_sel_e           x_sel,
  input  z_sel_e           z_sel,
  input  logic             sub,
  input  logic             cin,
  input  logic [M_W-1:0]   m,
  input  logic [P_W-1:0]   c,
  input  logic [11:0]      d_lo,
  input  logic [17:0]      a,
  input  logic [17:0]      b,
  input  logic [P_W-1:0]   pcin,
  input  logic [P_W-1:0]   p_fb,
  output logic [P_W:0]     r
);

  logic [P_W-1:0] x_op;
  logic [P_W-1:0] z_op;
  logic [P_W:0]   x_plus_cin;

  // Operand selection and the post-adder; bit 48 of r is carry (add) or borrow (subtract).
  always_comb begin
    x_op = '0;
    z_op = '0;
    unique case (x_sel)
      X_ZERO: x_op = '0;
      X_M:    x_op = {{(P_W - M_W){1'b0}}, m};
      X_P:    x_op = p_fb;
      X_DAB:  x_op = {d_lo, a, b};
      default: x_op = '0;
    endcase
    unique case (z_sel)
      Z_ZERO: z_op = '0;
      Z_PCIN: z_op = pcin;
      Z_P:    z_op = p_fb;
      Z_C:    z_op = c;
      default: z_op = '0;
    endcase
    x_plus_cin = {1'b0, x_op} + {{P_W{1'b0}}, cin};
    if (sub) r = {1'b0, z_op} - x_plus_cin;
    else     r = {1'b0, z_op} + x_plus_cin;
  end

endmodule

// File: rtl/dsp_post_adder_acc.sv
// Purpose: DSP48A1 post-adder/accumulator: P = Z +/- (X + CIN), registered P/CARRYOUT with feedback.
// Latency: 1 cycle operands->P; OPMODE and carry-in take effect one cycle after presentation.
// Backpressure: none; CE low freezes the corresponding register.
module dsp_post_adder_acc
  import dsp48a1_pkg::*;
#(
  parameter int OPMODEREG   = 1,
  parameter int CARRYINREG  = 1,
  parameter int PREG        = 1,
  parameter int CARRYOUTREG = 1,
  parameter     CARRYINSEL  = "OPMODE5"
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             CEOPMODE,
  input  logic             CECARRYIN,
  input  logic             CEP,
  input  logic [7:0]       OPMODE,
  input  logic [M_W-1:0]   M,
  input  logic [P_W-1:0]   C,
  input  logic [17:0]      D,
  input  logic [17:0]      A,
  input  logic [17:0]      B,
  input  logic [P_W-1:0]   PCIN,
  input  logic             CARRYIN,
  output logic [P_W-1:0]   P,
  output logic [P_W-1:0]   PCOUT,
  output logic             CARRYOUT,
  output logic             CARRYOUTF
);

  localparam bit CIN_FROM_PORT = (CARRYINSEL == "CARRYIN");

  logic [7:0]     opm;
  logic           cin_src;
  logic           cin;
  logic [P_W:0]   r;
  logic [P_W-1:0] p_fb;
  logic           unused_bits;

  assign unused_bits = ^{D[17:12], opm[6], opm[4], OPMODE[6], OPMODE[4], CARRYIN, OPMODE[OPM_CIN]};

  generate
    if (OPMODEREG != 0) begin : g_opm_reg
      logic [7:0] opm_q;
      // OPMODE pipeline stage; bits 4 and 6 are carried along but never used.
      always_ff @(posedge CLK) begin
        if (reset)         opm_q <= '0;
        else if (CEOPMODE) opm_q <= OPMODE;
      end
      assign opm = opm_q;
    end else begin : g_opm_comb
      assign opm = OPMODE;
    end
  endgenerate

  // With a carry-in register the raw OPMODE[5] is sampled so that it lines up with the
  // registered OPMODE; without one it is taken from the (possibly registered) OPMODE.
  generate
    if (CIN_FROM_PORT) begin : g_cin_port
      assign cin_src = CARRYIN;
    end else if (CARRYINREG != 0) begin : g_cin_opm_raw
      assign cin_src = OPMODE[OPM_CIN];
    end else begin : g_cin_opm
      assign cin_src = opm[OPM_CIN];
    end
  endgenerate

  generate
    if (CARRYINREG != 0) begin : g_cin_reg
      logic cin_q;
      // Carry-in pipeline stage.
      always_ff @(posedge CLK) begin
        if (reset)          cin_q <= 1'b0;
        else if (CECARRYIN) cin_q <= cin_src;
      end
      assign cin = cin_q;
    end else begin : g_cin_comb
      assign cin = cin_src;
    end
  endgenerate

  dsp_post_adder_core u_core (
    .x_sel (opm_x(opm)),
    .z_sel (opm_z(opm)),
    .sub   (opm[OPM_SUB]),
    .cin   (cin),
    .m     (M),
    .c     (C),
    .d_lo  (D[11:0]),
    .a     (A),
    .b     (B),
    .pcin  (PCIN),
    .p_fb  (p_fb),
    .r     (r)
  );

  generate
    if (PREG != 0) begin : g_p_reg
      logic [P_W-1:0] p_q;
      // P register; a held P remains the feedback operand.
      always_ff @(posedge CLK) begin
        if (reset)    p_q <= '0;
        else if (CEP) p_q <= r[P_W-1:0];
      end
      assign P    = p_q;
      assign p_fb = p_q;
    end else begin : g_p_comb
      assign P = r[P_W-1:0];
      // Feedback without a P register would be a combinational loop; tie it off and flag use.
      assign p_fb = '0;
      // Flag any selection of P as an operand while P is unregistered.
      always_ff @(posedge CLK) begin
        if (!reset) begin
          assert (opm[1:0] != X_P && opm[3:2] != Z_P)
            else $error("P feedback selected with PREG=0");
        end
      end
    end
  endgenerate

  generate
    if (CARRYOUTREG != 0) begin : g_co_reg
      logic co_q;
      // CARRYOUT register, enabled together with the carry-in stage.
      always_ff @(posedge CLK) begin
        if (reset)          co_q <= 1'b0;
        else if (CECARRYIN) co_q <= r[P_W];
      end
      assign CARRYOUT = co_q;
    end else begin : g_co_comb
      assign CARRYOUT = r[P_W];
    end
  endgenerate

  assign PCOUT     = P;
  assign CARRYOUTF = CARRYOUT;

endmodule

// File: tb/tb_dsp_post_adder_acc.sv
// Purpose: directed scoreboard bench for dsp_post_adder_acc (default parameters).
// Latency: expectations are tagged with the clock edge after which they must hold.
// Backpressure: n/a.
module tb_dsp_post_adder_acc;

  logic        CLK = 1'b0;
  logic        reset;
  logic        CEOPMODE, CECARRYIN, CEP;
  logic [7:0]  OPMODE;
  logic [35:0] M;
  logic [47:0] C, PCIN;
  logic [17:0] D, A, B;
  logic        CARRYIN;
  logic [47:0] P, PCOUT;
  logic        CARRYOUT, CARRYOUTF;

  dsp_post_adder_acc dut (
    .CLK       (CLK),
    .reset     (reset),
    .CEOPMODE  (CEOPMODE),
    .CECARRYIN (CECARRYIN),
    .CEP       (CEP),
    .OPMODE    (OPMODE),
    .M         (M),
    .C         (C),
    .D         (D),
    .A         (A),
    .B         (B),
    .PCIN      (PCIN),
    .CARRYIN   (CARRYIN),
    .P         (P),
    .PCOUT     (PCOUT),
    .CARRYOUT  (CARRYOUT),
    .CARRYOUTF (CARRYOUTF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          cyc;
    logic [47:0] p;
    logic        co;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t e_mon;

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: at each falling edge, retire every expectation due at this edge count.
  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e_mon = sb.pop_front();
      total = total + 1;
      if (e_mon.cyc < cyc) begin
        bad = bad + 1;
        $display("FAIL %s: expectation for edge %0d not retired (now %0d)", e_mon.name, e_mon.cyc, cyc);
      end else begin
        if (P !== e_mon.p || PCOUT !== e_mon.p) begin
          bad = bad + 1;
          $display("FAIL %s p: P=%h PCOUT=%h expected %h", e_mon.name, P, PCOUT, e_mon.p);
        end
        total = total + 1;
        if (CARRYOUT !== e_mon.co || CARRYOUTF !== e_mon.co) begin
          bad = bad + 1;
          $display("FAIL %s carry: CARRYOUT=%b CARRYOUTF=%b expected %b",
                   e_mon.name, CARRYOUT, CARRYOUTF, e_mon.co);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic expect_at(input int ofs, input logic [47:0] p, input logic co, input string name);
    exp_t e;
    e.cyc  = cyc + ofs;
    e.p    = p;
    e.co   = co;
    e.name = name;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; CEOPMODE = 1'b1; CECARRYIN = 1'b1; CEP = 1'b1;
    OPMODE = 8'h00; M = '0; C = '0; PCIN = '0; D = '0; A = '0; B = '0; CARRYIN = 1'b0;

    // Reset with all enables high.
    expect_at(1, 48'd0, 1'b0, "reset1");
    expect_at(2, 48'd0, 1'b0, "reset2");
    tick(2);

    // X=M, Z=C: opmode register adds one edge before the sum appears.
    reset = 1'b0; OPMODE = 8'h0D; M = 36'd100; C = 48'd5;
    expect_at(2, 48'd105, 1'b0, "add");
    tick(2);

    // Accumulate from a cleared P: reset also clears the opmode register,
    // so the first edge after release still sees X=0,Z=0.
    reset = 1'b1; OPMODE = 8'h09; M = 36'd3; C = 48'd0;
    tick(1);
    reset = 1'b0;
    expect_at(1, 48'd0,  1'b0, "acc0");
    expect_at(2, 48'd3,  1'b0, "acc3");
    expect_at(3, 48'd6,  1'b0, "acc6");
    expect_at(4, 48'd9,  1'b0, "acc9");
    expect_at(5, 48'd12, 1'b0, "acc12");
    tick(5);
    CEP = 1'b0;
    expect_at(1, 48'd12, 1'b0, "hold1");
    expect_at(2, 48'd12, 1'b0, "hold2");
    tick(2);
    CEP = 1'b1;

    // Subtract with borrow, then without.
    OPMODE = 8'h8D; C = 48'd10; M = 36'd15;
    expect_at(2, 48'hFFFF_FFFF_FFFB, 1'b1, "sub_borrow");
    tick(2);
    M = 36'd4;
    expect_at(1, 48'd6, 1'b0, "sub_pos");
    tick(1);

    // All-ones C plus carry-in wraps to zero with carry out.
    OPMODE = 8'h2D; C = 48'hFFFF_FFFF_FFFF; M = 36'd0;
    expect_at(2, 48'd0, 1'b1, "wrap");
    tick(2);

    // Reset in the middle of accumulation.
    reset = 1'b1; OPMODE = 8'h09; M = 36'd3; C = 48'd0;
    tick(1);
    reset = 1'b0;
    expect_at(2, 48'd3, 1'b0, "racc3");
    expect_at(3, 48'd6, 1'b0, "racc6");
    tick(3);
    reset = 1'b1;
    expect_at(1, 48'd0, 1'b0, "mid_reset");
    tick(1);
    reset = 1'b0;
    expect_at(1, 48'd0, 1'b0, "post_reset_opm0");
    expect_at(2, 48'd3, 1'b0, "post_reset_acc");
    tick(2);

    // PCIN path: Z=PCIN, X=M.
    OPMODE = 8'h05; PCIN = 48'd7; M = 36'd1;
    expect_at(2, 48'd8, 1'b0, "pcin");
    tick(2);

    // X=P and Z=P together: P doubles each edge.
    OPMODE = 8'h0A;
    expect_at(1, 48'd8,  1'b0, "dbl_lag");
    expect_at(2, 48'd16, 1'b0, "dbl16");
    expect_at(3, 48'd32, 1'b0, "dbl32");
    tick(3);

    tick(3);
    total = total + 1;
    if (sb.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
